calc_input_stage: RTL and testbench

- Front end for the calculator datapath. Conditions the raw board inputs before they reach the accumulator/ALU block.
- Synchronises the mechanical buttons and slide switches, and debounces the buttons.
- Converts each press of the centre (load) button into a single-cycle load pulse.
- Downstream, the calculator consumes the pulse as its load enable, the debounced left/right/down levels as its opcode, and the synchronised switches as its operand.

---
 rtl/calc_pkg.sv | 13 +
 rtl/calc_input_if.sv | 24 ++
 rtl/debounce_ch.sv | 67 ++++++
 rtl/calc_input_stage.sv | 77 +++++++
 tb/tb_calc_input_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator input stage.
package calc_pkg;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} deb_state_t;

  localparam int DATA_W = 16;

  // Opcode bit positions; the centre button sits above them in the channel vector.
  localparam int OP_L = 2;
  localparam int OP_R = 1;
  localparam int OP_D = 0;
  localparam int CH_C = 3;
  localparam int NUM_CH = 4;
endpackage

// File: rtl/calc_input_if.sv
// Board-side buttons/switches and conditioned outputs of the calculator input stage.
interface calc_input_if
  import calc_pkg::*;
();
  logic              btnc_raw;
  logic              btnl_raw;
  logic              btnr_raw;
  logic              btnd_raw;
  logic [DATA_W-1:0] sw_raw;
  logic              btnc_pulse;
  logic              btnl_db;
  logic              btnr_db;
  logic              btnd_db;
  logic [DATA_W-1:0] sw_q;

  modport master (
    output btnc_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
    input  btnc_pulse, btnl_db, btnr_db, btnd_db, sw_q
  );
  modport slave (
    input  btnc_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
    output btnc_pulse, btnl_db, btnr_db, btnd_db, sw_q
  );
endinterface

// File: rtl/debounce_ch.sv
// One button channel: synchroniser chain, debounce FSM with stability counter,
// debounced level and a one-cycle strobe on each accepted rising change.
module debounce_ch
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       db,
  output logic       rise,
  output deb_state_t state
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FIRST = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // cnt holds the number of stable samples seen so far; the sample that opens a
  // WAIT state is the first one, so the level flips after exactly
  // DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      state <= IDLE_LOW;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      case (state)
        IDLE_LOW: if (s) begin
          state <= WAIT_HIGH;
          cnt   <= FIRST;
        end
        WAIT_HIGH: begin
          if (!s) state <= IDLE_LOW;
          else if (cnt == LAST) begin
            state <= IDLE_HIGH;
            db    <= 1'b1;
            rise  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        IDLE_HIGH: if (!s) begin
          state <= WAIT_LOW;
          cnt   <= FIRST;
        end
        WAIT_LOW: begin
          if (s) state <= IDLE_HIGH;
          else if (cnt == LAST) begin
            state <= IDLE_LOW;
            db    <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end
endmodule

// File: rtl/calc_input_stage.sv
// Calculator input front end: four debounced buttons, synchronised switches,
// centre-press load strobe. Define CALC_INPUT_AUTO_REPEAT_EN for held-button auto-repeat.
module calc_input_stage
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic         clk,
  input logic         btnac,
  calc_input_if.slave io
);
  logic [NUM_CH-1:0]          raw;
  logic [NUM_CH-1:0]          db;
  logic [NUM_CH-1:0]          rise;
  logic [NUM_CH-1:0][1:0]     st;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync;
  logic                       unused;

  assign raw[CH_C] = io.btnc_raw;
  assign raw[OP_L] = io.btnl_raw;
  assign raw[OP_R] = io.btnr_raw;
  assign raw[OP_D] = io.btnd_raw;

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch [NUM_CH-1:0] (
    .clk  (clk),
    .rst  (btnac),
    .raw  (raw),
    .db   (db),
    .rise (rise),
    .state(st)
  );

  // Switches are only synchronised; the operand is sampled on the load strobe.
  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) sw_sync <= '0;
    else       sw_sync <= {sw_sync[SYNC_STAGES-2:0], io.sw_raw};
  end

  assign io.sw_q    = sw_sync[SYNC_STAGES-1];
  assign io.btnl_db = db[OP_L];
  assign io.btnr_db = db[OP_R];
  assign io.btnd_db = db[OP_D];

`ifdef CALC_INPUT_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt;
  logic          rep;

  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else begin
      rep <= 1'b0;
      if (st[CH_C] != IDLE_HIGH) rcnt <= '0;
      else if (rcnt == RLAST) begin
        rcnt <= '0;
        rep  <= 1'b1;
      end else rcnt <= rcnt + 1'b1;
    end
  end

  assign io.btnc_pulse = rise[CH_C] | rep;
`else
  assign io.btnc_pulse = rise[CH_C];
`endif

  // Opcode channels never need a strobe, and only the centre state drives repeat.
  assign unused = ^{rise[OP_L], rise[OP_R], rise[OP_D], st};
endmodule

// File: tb/tb_calc_input_stage.sv
// Directed bench for calc_input_stage with short debounce/repeat intervals.
module tb_calc_input_stage;
  logic clk = 1'b0;
  logic btnac = 1'b1;
  int   tests = 0;
  int   fails = 0;

  calc_input_if bus();

  calc_input_stage #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk  (clk),
    .btnac(btnac),
    .io   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.btnc_raw = 1'b0;
    bus.btnl_raw = 1'b0;
    bus.btnr_raw = 1'b0;
    bus.btnd_raw = 1'b0;
    bus.sw_raw   = '0;
  endtask

  task automatic do_reset();
    btnac = 1'b1;
    clear_inputs();
    step();
    step();
    btnac = 1'b0;
  endtask

  // Steps n cycles; k counts edges from the call. Records first pulse cycle,
  // pulse count and first cycle where btnc_db changed; drops btnc after step drop_at.
  task automatic watch(input int n, input int drop_at,
                       output int first_p, output int np, output int chg);
    logic db0;
    db0 = dut.db[3];
    first_p = -1; np = 0; chg = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (bus.btnc_pulse === 1'b1) begin
        if (first_p < 0) first_p = k;
        np++;
      end
      if (chg < 0 && dut.db[3] !== db0) chg = k;
      if (k == drop_at) bus.btnc_raw = 1'b0;
    end
  endtask

  task automatic test_reset();
    int fp, np, chg;
    btnac = 1'b1;
    clear_inputs();
    bus.btnc_raw = 1'b1;
    bus.sw_raw   = 16'hffff;
    step();
    step();
    tests++;
    if ({bus.btnc_pulse, bus.btnl_db, bus.btnr_db, bus.btnd_db} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.btnc_pulse, bus.btnl_db, bus.btnr_db, bus.btnd_db});
    end
    tests++;
    if (bus.sw_q !== 16'h0000) begin
      fails++;
      $display("FAIL reset_sw_q got %h want 0000", bus.sw_q);
    end
    bus.sw_raw = '0;
    btnac = 1'b0;
    watch(10, -1, fp, np, chg);
    tests++;
    if (fp !== 6) begin fails++; $display("FAIL reset_held_pulse_at got %0d want 6", fp); end
    tests++;
    if (np !== 1) begin fails++; $display("FAIL reset_held_pulses got %0d want 1", np); end
    tests++;
    if (chg !== 6) begin fails++; $display("FAIL reset_held_db_at got %0d want 6", chg); end
  endtask

  task automatic test_bounce();
    int fp, np, chg;
    do_reset();
    bus.btnc_raw = 1'b1; step();
    bus.btnc_raw = 1'b0; step();
    bus.btnc_raw = 1'b1; step();
    bus.btnc_raw = 1'b0; step();
    bus.btnc_raw = 1'b1;
    watch(12, -1, fp, np, chg);
    tests++;
    if (np !== 1) begin fails++; $display("FAIL bounce_pulses got %0d want 1", np); end
    tests++;
    if (fp !== 6) begin fails++; $display("FAIL bounce_pulse_at got %0d want 6", fp); end
  endtask

  task automatic test_glitch();
    int fp, np, chg;
    do_reset();
    bus.btnc_raw = 1'b1;
    watch(12, 3, fp, np, chg);
    tests++;
    if (np !== 0) begin fails++; $display("FAIL glitch3_pulses got %0d want 0", np); end
    tests++;
    if (chg !== -1) begin fails++; $display("FAIL glitch3_db_changed got %0d want -1", chg); end
    bus.btnc_raw = 1'b1;
    watch(12, 4, fp, np, chg);
    tests++;
    if (np !== 1) begin fails++; $display("FAIL glitch4_pulses got %0d want 1", np); end
    tests++;
    if (fp !== 6) begin fails++; $display("FAIL glitch4_pulse_at got %0d want 6", fp); end
  endtask

  task automatic test_release();
    int fp, np, chg;
    do_reset();
    bus.btnc_raw = 1'b1;
    watch(10, -1, fp, np, chg);
    tests++;
    if (bus.btnc_pulse !== 1'b0 || dut.db[3] !== 1'b1) begin
      fails++;
      $display("FAIL release_held got pulse=%b db=%b want 0 1", bus.btnc_pulse, dut.db[3]);
    end
    bus.btnc_raw = 1'b0;
    watch(12, -1, fp, np, chg);
    tests++;
    if (chg !== 6) begin fails++; $display("FAIL release_db_fall_at got %0d want 6", chg); end
    tests++;
    if (np !== 0) begin fails++; $display("FAIL release_pulses got %0d want 0", np); end
  endtask

  task automatic test_operand_opcode();
    bit got;
    do_reset();
    bus.sw_raw   = 16'h285a;
    bus.btnr_raw = 1'b1;
    step();
    tests++;
    if (bus.sw_q !== 16'h0000) begin fails++; $display("FAIL sw_q_cycle1 got %h want 0000", bus.sw_q); end
    step();
    tests++;
    if (bus.sw_q !== 16'h285a) begin fails++; $display("FAIL sw_q_cycle2 got %h want 285a", bus.sw_q); end
    step(); step(); step();
    tests++;
    if (bus.btnr_db !== 1'b0) begin fails++; $display("FAIL btnr_db_cycle5 got %b want 0", bus.btnr_db); end
    step();
    tests++;
    if (bus.btnr_db !== 1'b1) begin fails++; $display("FAIL btnr_db_cycle6 got %b want 1", bus.btnr_db); end
    bus.btnc_raw = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (bus.btnc_pulse === 1'b1) begin
        got = 1'b1;
        tests++;
        if ({bus.btnl_db, bus.btnr_db, bus.btnd_db} !== 3'b010) begin
          fails++;
          $display("FAIL opcode_at_load got %b want 010", {bus.btnl_db, bus.btnr_db, bus.btnd_db});
        end
      end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL load_pulse_seen got 0 want 1"); end
  endtask

  task automatic test_auto_repeat();
    int pidx[$];
    int exp_idx[$];
`ifdef CALC_INPUT_AUTO_REPEAT_EN
    exp_idx = '{6, 14, 22, 30, 38};
`else
    exp_idx = '{6};
`endif
    do_reset();
    bus.btnc_raw = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (bus.btnc_pulse === 1'b1) pidx.push_back(k);
      if (k == 40) bus.btnc_raw = 1'b0;
    end
    tests++;
    if (pidx.size() !== exp_idx.size()) begin
      fails++;
      $display("FAIL repeat_pulse_count got %0d want %0d", pidx.size(), exp_idx.size());
    end
    for (int i = 0; i < exp_idx.size() && i < pidx.size(); i++) begin
      tests++;
      if (pidx[i] !== exp_idx[i]) begin
        fails++;
        $display("FAIL repeat_pulse%0d_at got %0d want %0d", i, pidx[i], exp_idx[i]);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_bounce();
    test_glitch();
    test_release();
    test_operand_opcode();
    test_auto_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
